// File: rtl/n64_frame_tx.sv
// N64 joybus frame transmitter: serialises a right-justified command word
// MSB-first in the 4-unit pulse-width code, then appends the console stop bit.
module n64_frame_tx #(
    parameter int UNIT_CYCLES = 12,
    parameter int MAX_BITS    = 32,
    parameter int NB_W        = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MAX_BITS-1:0] data,
    input  logic [NB_W-1:0]     nbits,
    output logic                line_low,
    output logic                busy,
    output logic                done
);

    localparam int UW = $clog2(UNIT_CYCLES);
    localparam logic [UW-1:0]   UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [NB_W-1:0] MAX_N     = NB_W'(MAX_BITS);

    typedef enum logic [1:0] {IDLE, BIT, STOP, FIN} state_t;

    state_t              state;
    logic [MAX_BITS-1:0] shreg;
    logic [NB_W-1:0]     bit_cnt;
    logic [UW-1:0]       unit_cnt;
    logic [1:0]          phase;

    logic [NB_W-1:0] n_clamp;
    logic [NB_W-1:0] align;
    logic            cur_bit;
    logic            unit_wrap;

    always_comb begin
        n_clamp   = (nbits > MAX_N) ? MAX_N : nbits;
        align     = MAX_N - n_clamp;
        cur_bit   = shreg[MAX_BITS-1];
        unit_wrap = (unit_cnt == UNIT_LAST);
    end

    // line_low is loaded with the level for the *next* unit so it changes
    // exactly on unit boundaries straight out of a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            unit_cnt <= '0;
            phase    <= '0;
            line_low <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Left-align the active field so its first bit sits at the MSB.
                        shreg    <= data << align;
                        bit_cnt  <= n_clamp;
                        unit_cnt <= '0;
                        phase    <= '0;
                        busy     <= 1'b1;
                        line_low <= 1'b1;
                        state    <= (n_clamp != '0) ? BIT : STOP;
                    end
                end

                BIT: begin
                    if (!unit_wrap) begin
                        unit_cnt <= unit_cnt + UW'(1);
                    end else begin
                        unit_cnt <= '0;
                        if (phase == 2'd3) begin
                            phase    <= '0;
                            line_low <= 1'b1;
                            shreg    <= shreg << 1;
                            bit_cnt  <= bit_cnt - NB_W'(1);
                            if (bit_cnt == NB_W'(1)) begin
                                state <= STOP;
                            end
                        end else begin
                            phase    <= phase + 2'd1;
                            // A zero stays low through phase 2; a one releases after phase 0.
                            line_low <= !cur_bit && (phase != 2'd2);
                        end
                    end
                end

                STOP: begin
                    if (!unit_wrap) begin
                        unit_cnt <= unit_cnt + UW'(1);
                    end else begin
                        unit_cnt <= '0;
                        line_low <= 1'b0;
                        if (phase == 2'd2) begin
                            phase <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            phase <= phase + 2'd1;
                        end
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/n64_frame_tx.md
# n64_frame_tx

Parametrised N64 joybus frame transmitter. It latches a command word of 0 to MAX_BITS bits and serialises it MSB-first onto the single open-drain controller data line, using the 4-µs-per-bit pulse-width code. It appends the console stop bit and signals completion. It sits between the console-side command logic and the bidirectional pad, and replaces the fixed single-bit "send 0" cell with a full-frame, width-configurable sender.

## Interface
- UNIT_CYCLES, 12: clk cycles per 1 µs timing unit (≥2).
- MAX_BITS, 32: widest frame in bits (≥1).
- NB_W, $clog2(MAX_BITS+1): width of the nbits port.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- data  in  MAX_BITS  frame, right-justified; bit nbits-1 is sent first.
- nbits  in  NB_W  number of data bits to send; values above MAX_BITS are clamped to MAX_BITS.
- line_low  out  1  registered; 1 = drive pad low, 0 = release (pull-up high).
- busy  out  1  registered; high while a frame is on the line.
- done  out  1  registered; one-cycle pulse after the frame ends.

## Operation
- States: IDLE, BIT, STOP, FIN.
- IDLE: line_low=0, busy=0. On start=1:
  - latch data into the shift register;
  - latch the clamped nbits into the bit counter;
  - clear the unit counter and the phase counter;
  - go to BIT if nbits≠0, otherwise go to STOP.
- Unit counter counts 0..UNIT_CYCLES-1. Phase counter counts 0..3 and advances when the unit counter wraps.
- BIT: current bit = shift-register MSB of the active field.
  - Bit 0: line_low=1 for phases 0–2, 0 for phase 3.
  - Bit 1: line_low=1 for phase 0, 0 for phases 1–3.
  - At the end of phase 3, shift and decrement. When the count reaches 0, go to STOP; otherwise start the next bit at phase 0.
- STOP: line_low=1 for phase 0, 0 for phases 1–2. At the end of phase 2, go to FIN.
- FIN: lasts one cycle with done=1, busy=0, line_low=0, then returns to IDLE.
- start outside IDLE (including during FIN) is ignored. data and nbits are don't-care after the latch.
- Reset (any time, including mid-frame):
  - line_low=0, busy=0, done=0;
  - state=IDLE;
  - all counters and the shift register are cleared.
  - No partial frame resumes after reset is released.

## Timing
- Cycle 0 is the edge where start is accepted in IDLE. The frame occupies cycles 1..T, where T=(4·n+3)·UNIT_CYCLES and n is the clamped nbits.
- busy=1 on cycles 1..T. done=1 on cycle T+1 only.
- The earliest next accepted start is cycle T+2, so back-to-back frames have a one-cycle idle gap with the line released.
- Bit k (k=0 is the first bit) starts at cycle 1+4·k·UNIT_CYCLES.
  - Low time is 3·UNIT_CYCLES for a 0 and UNIT_CYCLES for a 1.
  - The stop bit starts at cycle 1+4·n·UNIT_CYCLES and is low for UNIT_CYCLES.
- line_low changes only on unit boundaries. It is glitch-free because it comes straight from a flop.
- Reset values: line_low=0, busy=0, done=0.

## Test plan
Benches use UNIT_CYCLES=4 and MAX_BITS=8.
- Reset then idle, start=0 for 50 cycles → line_low=0, busy=0, done=0 throughout.
- start with data=8'h00, nbits=8:
  - eight 16-cycle bits, each 12 low / 4 high;
  - stop bit 4 low / 8 high;
  - busy on cycles 1..140, done only on cycle 141.
- start with data=8'h0A, nbits=4 (sends 1010):
  - low widths 4, 12, 4, 12 at cycles 1, 17, 33, 49;
  - stop low at cycles 65–68; done on cycle 77.
- nbits=0 → stop bit only: low cycles 1–4, busy on cycles 1..12, done on cycle 13.
- nbits=9 with data=8'hFF → clamped to 8: all bits low 4 / high 12, done on cycle 141.
- Overlap and reset cases:
  - start pulsed again at cycle 20 of a frame → ignored; the frame is unchanged.
  - reset asserted at cycle 30 → all outputs 0 immediately.
  - after release, a new start produces a correct full frame.
